// File: rtl/enemy_field_engine.sv
// enemy_field_engine
//   Enemy-field controller for the shooter game. Owns N_SLOTS enemy slots that
//   march outward along 2**PATH_W radial paths through 2**RING_W rings. Handles
//   spawning, stepped movement, wrap-around shot windows, scoring and game flow.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        one-cycle pulse; starts or restarts a game
//   shoot_pulse  one-cycle pulse per shot
//   shot_mode    0 = wide shot window, 1 = narrow shot window
//   fast_mode    1 selects FAST_PERIOD spawn interval
//   ship_pose    current ship path
//   rand_path    random path for spawns
//   rand_type    random enemy type; also used as initial health
//   enemies      packed slots, slot k at [k*SLOT_W +: SLOT_W]
//                slot = {valid, ring, path, type[1:0], health[1:0]}
//   active_count number of valid slots on the enemies bus
//   score        current score (saturates at END_SCORE)
//   state        0 IDLE, 1 PLAY, 2 OVER
//   game_over    high in OVER
//   win          high in OVER when the game ended on score
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// PLAY  | game running: shots, movement, spawning, end detection
// OVER  | game ended; field cleared, score and win held until start

module enemy_field_engine #(
    parameter int N_SLOTS     = 8,
    parameter int PATH_W      = 4,
    parameter int RING_W      = 2,
    parameter int MIN_ACTIVE  = 2,
    parameter int MOVE_PERIOD = 200_000_000,
    parameter int SLOW_PERIOD = 200_000_000,
    parameter int FAST_PERIOD = 100_000_000,
    parameter int WIDE_HALF   = 2,
    parameter int NARROW_HALF = 1,
    parameter int END_SCORE   = 20,
    parameter int SCORE_W     = 6,
    localparam int SLOT_W     = 5 + RING_W + PATH_W,
    localparam int CNT_W      = $clog2(N_SLOTS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      shoot_pulse,
    input  logic                      shot_mode,
    input  logic                      fast_mode,
    input  logic [PATH_W-1:0]         ship_pose,
    input  logic [PATH_W-1:0]         rand_path,
    input  logic [1:0]                rand_type,
    output logic [N_SLOTS*SLOT_W-1:0] enemies,
    output logic [CNT_W-1:0]          active_count,
    output logic [SCORE_W-1:0]        score,
    output logic [1:0]                state,
    output logic                      game_over,
    output logic                      win
);

    localparam int DEPTH     = 2 ** RING_W;
    localparam int IDX_W     = $clog2(N_SLOTS);
    localparam int MOVE_W    = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int SPAWN_MAX = (SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD : FAST_PERIOD;
    localparam int SPAWN_W   = (SPAWN_MAX > 1) ? $clog2(SPAWN_MAX) : 1;
    // Wide enough for the held score plus every slot killed at type 3 in one shot.
    localparam int SUM_W     = SCORE_W + IDX_W + 3;

    localparam int HP_LSB    = 0;
    localparam int TYPE_LSB  = 2;
    localparam int PATH_LSB  = 4;
    localparam int RING_LSB  = 4 + PATH_W;
    localparam int VALID_BIT = SLOT_W - 1;

    localparam logic [MOVE_W-1:0]  MOVE_LAST = MOVE_W'(MOVE_PERIOD - 1);
    localparam logic [SPAWN_W-1:0] SLOW_LAST = SPAWN_W'(SLOW_PERIOD - 1);
    localparam logic [SPAWN_W-1:0] FAST_LAST = SPAWN_W'(FAST_PERIOD - 1);
    localparam logic [RING_W-1:0]  RING_LAST = RING_W'(DEPTH - 1);
    localparam logic [PATH_W-1:0]  WIDE_H    = PATH_W'(WIDE_HALF);
    localparam logic [PATH_W-1:0]  NARROW_H  = PATH_W'(NARROW_HALF);
    localparam logic [SUM_W-1:0]   END_SUM   = SUM_W'(END_SCORE);
    localparam logic [CNT_W-1:0]   MIN_ACT   = CNT_W'(MIN_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t               state_q;
    logic [SLOT_W-1:0]    slot_q [N_SLOTS];
    logic [MOVE_W-1:0]    move_cnt_q;
    logic [SPAWN_W-1:0]   spawn_cnt_q;

    logic [SLOT_W-1:0]    slot_d [N_SLOTS];
    logic [PATH_W-1:0]    half;
    logic [PATH_W-1:0]    ahead;
    logic [PATH_W-1:0]    behind;
    logic                 in_window;
    logic                 killed;
    logic                 move_tick;
    logic                 loss;
    logic [SUM_W-1:0]     gain;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic [SPAWN_W-1:0]   spawn_last;
    logic                 spawn_now;
    logic [SPAWN_W-1:0]   spawn_cnt_d;
    logic [CNT_W-1:0]     count_d;
    logic [SUM_W-1:0]     score_sum;
    logic                 reach_end;
    logic [SCORE_W-1:0]   score_d;

    // Next-field evaluation for one PLAY cycle. Everything is judged against
    // slot_q, so a slot freed by a kill only becomes spawnable next cycle.
    always_comb begin
        half      = shot_mode ? NARROW_H : WIDE_H;
        move_tick = (move_cnt_q == MOVE_LAST);
        gain      = '0;
        loss      = 1'b0;
        ahead     = '0;
        behind    = '0;
        in_window = 1'b0;
        killed    = 1'b0;
        slot_d    = slot_q;

        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_q[k][VALID_BIT]) begin
                // Modular distance in both directions handles the wrap at path 0.
                ahead     = slot_q[k][PATH_LSB +: PATH_W] - ship_pose;
                behind    = ship_pose - slot_q[k][PATH_LSB +: PATH_W];
                in_window = shoot_pulse && ((ahead <= half) || (behind <= half));
                killed    = in_window && (slot_q[k][HP_LSB +: 2] == 2'd0);
                if (killed) begin
                    gain      = gain + SUM_W'(slot_q[k][TYPE_LSB +: 2]) + SUM_W'(1);
                    slot_d[k] = '0;
                end else begin
                    if (in_window) begin
                        slot_d[k][HP_LSB +: 2] = slot_q[k][HP_LSB +: 2] - 2'd1;
                    end
                    if (move_tick) begin
                        if (slot_q[k][RING_LSB +: RING_W] == RING_LAST) begin
                            loss = 1'b1;
                        end else begin
                            slot_d[k][RING_LSB +: RING_W] = slot_q[k][RING_LSB +: RING_W] + 1'b1;
                        end
                    end
                end
            end
        end

        // Descending scan so the lowest free index is the one that sticks.
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (!slot_q[k][VALID_BIT]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(k);
            end
        end

        // >= rather than == so a slow->fast switch mid-count still terminates,
        // and a full field leaves the counter parked at terminal.
        spawn_last  = fast_mode ? FAST_LAST : SLOW_LAST;
        spawn_now   = 1'b0;
        spawn_cnt_d = spawn_cnt_q;
        if (active_count < MIN_ACT) begin
            spawn_now   = free_found;
            spawn_cnt_d = '0;
        end else if (spawn_cnt_q >= spawn_last) begin
            if (free_found) begin
                spawn_now   = 1'b1;
                spawn_cnt_d = '0;
            end
        end else begin
            spawn_cnt_d = spawn_cnt_q + 1'b1;
        end
        if (spawn_now) begin
            slot_d[free_idx] = {1'b1, {RING_W{1'b0}}, rand_path, rand_type, rand_type};
        end

        count_d = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            count_d = count_d + CNT_W'(slot_d[k][VALID_BIT]);
        end

        score_sum = SUM_W'(score) + gain;
        reach_end = (score_sum >= END_SUM);
        score_d   = reach_end ? SCORE_W'(END_SCORE) : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            slot_q       <= '{default: '0};
            move_cnt_q   <= '0;
            spawn_cnt_q  <= '0;
            active_count <= '0;
            score        <= '0;
            game_over    <= 1'b0;
            win          <= 1'b0;
        end else if (start) begin
            // Start from any state (including mid-game) begins a fresh game.
            state_q      <= ST_PLAY;
            slot_q       <= '{default: '0};
            move_cnt_q   <= '0;
            spawn_cnt_q  <= '0;
            active_count <= '0;
            score        <= '0;
            game_over    <= 1'b0;
            win          <= 1'b0;
        end else if (state_q == ST_PLAY) begin
            score <= score_d;
            if (reach_end || loss) begin
                // Score takes priority over a simultaneous loss.
                state_q      <= ST_OVER;
                slot_q       <= '{default: '0};
                move_cnt_q   <= '0;
                spawn_cnt_q  <= '0;
                active_count <= '0;
                game_over    <= 1'b1;
                win          <= reach_end;
            end else begin
                slot_q       <= slot_d;
                move_cnt_q   <= move_tick ? '0 : move_cnt_q + 1'b1;
                spawn_cnt_q  <= spawn_cnt_d;
                active_count <= count_d;
            end
        end
    end

    always_comb begin
        enemies = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            enemies[k*SLOT_W +: SLOT_W] = slot_q[k];
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_enemy_field_engine.sv
// Randomized bench for enemy_field_engine with a slot-level reference model.
module tb_enemy_field_engine;

    localparam int N_SLOTS     = 4;
    localparam int PATH_W      = 4;
    localparam int RING_W      = 2;
    localparam int MIN_ACTIVE  = 2;
    localparam int MOVE_PERIOD = 8;
    localparam int SLOW_PERIOD = 12;
    localparam int FAST_PERIOD = 5;
    localparam int WIDE_HALF   = 2;
    localparam int NARROW_HALF = 1;
    localparam int END_SCORE   = 20;
    localparam int SCORE_W     = 6;
    localparam int SLOT_W      = 5 + RING_W + PATH_W;
    localparam int CNT_W       = $clog2(N_SLOTS + 1);
    localparam int N_PATHS     = 2 ** PATH_W;
    localparam int DEPTH       = 2 ** RING_W;
    localparam int S_IDLE = 0, S_PLAY = 1, S_OVER = 2;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      start = 1'b0;
    logic                      shoot_pulse = 1'b0;
    logic                      shot_mode = 1'b0;
    logic                      fast_mode = 1'b0;
    logic [PATH_W-1:0]         ship_pose = '0;
    logic [PATH_W-1:0]         rand_path = '0;
    logic [1:0]                rand_type = '0;
    logic [N_SLOTS*SLOT_W-1:0] enemies;
    logic [CNT_W-1:0]          active_count;
    logic [SCORE_W-1:0]        score;
    logic [1:0]                state;
    logic                      game_over;
    logic                      win;

    enemy_field_engine #(
        .N_SLOTS(N_SLOTS), .PATH_W(PATH_W), .RING_W(RING_W), .MIN_ACTIVE(MIN_ACTIVE),
        .MOVE_PERIOD(MOVE_PERIOD), .SLOW_PERIOD(SLOW_PERIOD), .FAST_PERIOD(FAST_PERIOD),
        .WIDE_HALF(WIDE_HALF), .NARROW_HALF(NARROW_HALF), .END_SCORE(END_SCORE),
        .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .shoot_pulse(shoot_pulse),
        .shot_mode(shot_mode), .fast_mode(fast_mode), .ship_pose(ship_pose),
        .rand_path(rand_path), .rand_type(rand_type), .enemies(enemies),
        .active_count(active_count), .score(score), .state(state),
        .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int v;
        int ring;
        int path;
        int typ;
        int hp;
    } eslot_t;

    eslot_t m [N_SLOTS];
    int     m_state, m_score, m_win, m_move, m_spawn;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int count_valid(input eslot_t s [N_SLOTS]);
        int c = 0;
        for (int k = 0; k < N_SLOTS; k++) c += s[k].v;
        return c;
    endfunction

    function automatic logic [N_SLOTS*SLOT_W-1:0] model_bus();
        logic [N_SLOTS*SLOT_W-1:0] b;
        b = '0;
        for (int k = 0; k < N_SLOTS; k++)
            b[k*SLOT_W +: SLOT_W] = {1'(m[k].v), 2'(m[k].ring), 4'(m[k].path), 2'(m[k].typ), 2'(m[k].hp)};
        return b;
    endfunction

    task automatic model_clear_field();
        for (int k = 0; k < N_SLOTS; k++) m[k] = '{0, 0, 0, 0, 0};
        m_move  = 0;
        m_spawn = 0;
    endtask

    task automatic model_reset();
        model_clear_field();
        m_state = S_IDLE;
        m_score = 0;
        m_win   = 0;
    endtask

    task automatic model_enter_play();
        model_clear_field();
        m_state = S_PLAY;
        m_score = 0;
        m_win   = 0;
    endtask

    // One clock of game rules, applied to the inputs present at the edge.
    task automatic model_step();
        eslot_t pre [N_SLOTS];
        int gain, half, d, free_k, period;
        bit tick, loss, killed, do_spawn;
        if (start) begin
            model_enter_play();
        end else if (m_state == S_PLAY) begin
            pre  = m;
            gain = 0;
            loss = 0;
            tick = (m_move == MOVE_PERIOD - 1);
            half = shot_mode ? NARROW_HALF : WIDE_HALF;
            for (int k = 0; k < N_SLOTS; k++) begin
                if (pre[k].v != 0) begin
                    killed = 0;
                    d = (pre[k].path - int'(ship_pose) + N_PATHS) % N_PATHS;
                    if (shoot_pulse && (d <= half || d >= N_PATHS - half)) begin
                        if (pre[k].hp == 0) begin
                            killed = 1;
                            gain  += pre[k].typ + 1;
                            m[k]   = '{0, 0, 0, 0, 0};
                        end else begin
                            m[k].hp = pre[k].hp - 1;
                        end
                    end
                    if (!killed && tick) begin
                        if (pre[k].ring == DEPTH - 1) loss = 1;
                        else m[k].ring = pre[k].ring + 1;
                    end
                end
            end
            m_move = tick ? 0 : m_move + 1;

            free_k = -1;
            for (int k = 0; k < N_SLOTS; k++)
                if (pre[k].v == 0 && free_k < 0) free_k = k;
            period   = fast_mode ? FAST_PERIOD : SLOW_PERIOD;
            do_spawn = 0;
            if (count_valid(pre) < MIN_ACTIVE) begin
                do_spawn = (free_k >= 0);
                m_spawn  = 0;
            end else if (m_spawn >= period - 1) begin
                if (free_k >= 0) begin
                    do_spawn = 1;
                    m_spawn  = 0;
                end
            end else begin
                m_spawn++;
            end
            if (do_spawn) m[free_k] = '{1, 0, int'(rand_path), int'(rand_type), int'(rand_type)};

            m_score = (m_score + gain > END_SCORE) ? END_SCORE : m_score + gain;
            if (m_score >= END_SCORE) begin
                m_state = S_OVER;
                m_win   = 1;
                model_clear_field();
            end else if (loss) begin
                m_state = S_OVER;
                m_win   = 0;
                model_clear_field();
            end
        end
    endtask

    task automatic check_all(input string phase);
        check_eq({phase, ".enemies"}, 64'(enemies), 64'(model_bus()));
        check_eq({phase, ".active_count"}, 64'(active_count), 64'(count_valid(m)));
        check_eq({phase, ".score"}, 64'(score), 64'(m_score));
        check_eq({phase, ".state"}, 64'(state), 64'(m_state));
        check_eq({phase, ".game_over"}, 64'(game_over), 64'(m_state == S_OVER));
        check_eq({phase, ".win"}, 64'(win), 64'(m_win));
    endtask

    task automatic step_and_check(input string phase);
        @(posedge clk);
        model_step();
        #1;
        check_all(phase);
    endtask

    task automatic drive_random();
        int live[$];
        int off;
        start       = (m_state != S_PLAY) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
        shoot_pulse = ($urandom_range(0, 1) == 1);
        shot_mode   = ($urandom_range(0, 1) == 1);
        fast_mode   = ($urandom_range(0, 1) == 1);
        rand_path   = PATH_W'($urandom);
        rand_type   = 2'($urandom);
        ship_pose   = PATH_W'($urandom);
        for (int k = 0; k < N_SLOTS; k++) if (m[k].v != 0) live.push_back(k);
        // Aim near a live enemy most of the time so kills and wins happen.
        if (live.size() > 0 && $urandom_range(0, 3) != 0) begin
            off = int'($urandom_range(0, 4)) - 2;
            ship_pose = PATH_W'(m[live[$urandom_range(0, live.size() - 1)]].path + off);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Quiet game: spawn pacing and march to a loss with no shots.
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            start       = (i == 0);
            shoot_pulse = 1'b0;
            fast_mode   = 1'b0;
            ship_pose   = PATH_W'($urandom);
            rand_path   = PATH_W'($urandom);
            rand_type   = 2'($urandom);
            step_and_check("quiet");
        end

        for (int i = 0; i < 6000; i++) begin
            if (i == 2000 || i == 4000) begin
                async_reset();
            end else begin
                @(negedge clk);
                drive_random();
                step_and_check("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/enemy_field_engine.md
Name: enemy_field_engine

Overview:
- Parametrised enemy-field controller for the shooter game; successor to the fixed 8-slot engine.
- Owns N_SLOTS enemy slots on N_PATHS radial paths with DEPTH rings; handles spawning, stepped movement, wrap-around shot windows, scoring and game-flow FSM.
- Sits between the input-conditioning blocks (shot pulse, ship pose, random sources) and the renderer, which consumes the packed slot bus.

Parameters:
N_SLOTS, 8, number of enemy slots (2..16)
PATH_W, 4, path index width; N_PATHS = 2**PATH_W
RING_W, 2, ring index width; DEPTH = 2**RING_W
MIN_ACTIVE, 2, active count below which one enemy spawns every cycle
MOVE_PERIOD, 200_000_000, clk cycles per movement step
SLOW_PERIOD, 200_000_000, spawn period when fast_mode=0
FAST_PERIOD, 100_000_000, spawn period when fast_mode=1
WIDE_HALF, 2, shot half-width in paths when shot_mode=0
NARROW_HALF, 1, shot half-width in paths when shot_mode=1
END_SCORE, 20, winning score
SCORE_W, 6, score width; must hold END_SCORE+4

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; starts or restarts a game
shoot_pulse  in  1  one-cycle pulse per shot
shot_mode  in  1  0 = wide window, 1 = narrow window
fast_mode  in  1  selects FAST_PERIOD spawn interval
ship_pose  in  PATH_W  current ship path
rand_path  in  PATH_W  random path for spawns
rand_type  in  2  random type; also initial health
enemies  out  N_SLOTS*SLOT_W  packed slots, slot k at [k*SLOT_W +: SLOT_W]
active_count  out  $clog2(N_SLOTS+1)  number of valid slots
score  out  SCORE_W  current score
state  out  2  0 IDLE, 1 PLAY, 2 OVER
game_over  out  1  high in OVER
win  out  1  high in OVER if end was by score

Behaviour:
- Slot format (SLOT_W = 5+RING_W+PATH_W, MSB first): valid, ring, path, type[1:0], health[1:0].
- Reset: state=IDLE, all slots 0, active_count=0, score=0, game_over=0, win=0, all counters 0.
- IDLE: start goes to PLAY. Other inputs are ignored.
- OVER: slots and counters are cleared on entry; score and win are held. start goes to PLAY.
- Entering PLAY: slots, score, counters and win are cleared on that edge.
- In PLAY, each cycle evaluates in this order against the slot values registered at the start of the cycle.
- Shot (if shoot_pulse):
  - Window = paths (ship_pose + d) mod N_PATHS, for d in [-H, +H], where H = shot_mode ? NARROW_HALF : WIDE_HALF.
  - Every valid slot in the window is hit once.
  - If health==0, the slot is cleared and score gains type+1. Otherwise health decrements.
  - All hits in one shot sum in the same cycle. Score saturates at END_SCORE.
- Move: move counter runs 0..MOVE_PERIOD-1. At terminal count every valid, non-killed slot advances ring+1.
  - A valid slot already at ring DEPTH-1 at a move tick causes a loss.
  - Slots hit but not killed in the same cycle still move.
- Spawn: at most one per cycle, into the lowest-index slot that is invalid at the start of the cycle.
  - Slots freed this cycle are reusable next cycle.
  - New slot = {1, ring 0, rand_path, rand_type, rand_type}.
  - If active_count < MIN_ACTIVE: spawn every cycle; the spawn counter holds at 0.
  - Otherwise the spawn counter runs 0..P-1, with P chosen by fast_mode sampled each cycle. At the terminal count it spawns and resets.
  - If all slots are full at the terminal count, the counter holds at terminal and spawns on the first cycle a slot is free.
- End conditions:
  - If the updated score >= END_SCORE: next state OVER, win=1.
  - Otherwise, a loss gives next state OVER, win=0.
  - If both occur in the same cycle, win=1.
- active_count is registered. It equals the popcount of the valid bits of the enemies output on the same cycle.
- start during PLAY restarts the game: same as entering PLAY.
- Reset mid-game returns to IDLE immediately (asynchronous).

Test Plan:
- N_SLOTS=4, MOVE_PERIOD=8, start pulse -> slots 0 and 1 valid on the next two cycles; active_count=2; slot 2 spawns after SLOW_PERIOD more cycles.
- ship_pose=15, WIDE_HALF=2, enemies on paths 1, 2, 13 with health 0 and types 0, 1, 3 -> slots on paths 1 and 13 cleared; score += 1+4 = 5; path 2 untouched.
- Enemy with health 2 on ship_pose, three shots -> health 1, then 0, then cleared; score += type+1 on the third shot only.
- Enemy at ring DEPTH-1 at a move tick -> state=OVER, game_over=1, win=0, all slots 0 on the next cycle.
- score=18, shot kills a type-3 enemy in the same cycle as a move-tick loss -> score=20 (saturated), state=OVER, win=1.
- All slots full, spawn counter at terminal, a kill frees slot 2 -> counter holds; slot 2 respawns the following cycle with ring 0.
